// File: rtl/regbank_read_unit_if.sv
// Request/response bundle between an operand consumer and regbank_read_unit.
// The master drives requests and response acceptance; the slave returns registered operands.
interface regbank_read_unit_if #(
    parameter int unsigned DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    src_a;
    logic [3:0]    src_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;

    modport master (
        output req_valid, src_a, src_b, rsp_ready,
        input  req_ready, rsp_valid, data_a, data_b
    );

    modport slave (
        input  req_valid, src_a, src_b, rsp_ready,
        output req_ready, rsp_valid, data_a, data_b
    );
endinterface

// File: rtl/regbank_read_unit.sv
// Read front end of the 16 x 32 register bank: two registered operand ports with write forwarding.
// Define REGBANK_READ_R0_ZERO_EN to make R0 read as hard-wired zero (no forwarding to R0).
module regbank_read_unit #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREGS*DW-1:0] regs_flat,
    input  logic [NREGS-1:0]    wr_en,
    input  logic [DW-1:0]       wr_data,
    regbank_read_unit_if.slave  bus,
    output logic                wr_onehot_err,
    output logic [CNT_W-1:0]    rd_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          take;
    logic          load;
    logic          multi_hot;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_hot = |(wr_en & (wr_en - NREGS'(1)));

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        bus.req_ready = (state_q == EMPTY) | bus.rsp_ready;
        accept        = bus.req_valid & bus.req_ready;
        take          = (state_q == FULL) & bus.rsp_ready;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (accept) begin
                    load = 1'b1;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        op_a = regs_flat[bus.src_a*DW +: DW];
        op_b = regs_flat[bus.src_b*DW +: DW];
        if (!multi_hot && wr_en[bus.src_a]) op_a = wr_data;
        if (!multi_hot && wr_en[bus.src_b]) op_b = wr_data;
`ifdef REGBANK_READ_R0_ZERO_EN
        if (bus.src_a == 4'd0) op_a = '0;
        if (bus.src_b == 4'd0) op_b = '0;
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_a <= '0;
            bus.data_b <= '0;
        end else if (load) begin
            bus.data_a <= op_a;
            bus.data_b <= op_b;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_onehot_err <= 1'b0;
            rd_count      <= '0;
        end else begin
            if (multi_hot) wr_onehot_err <= 1'b1;
            if (take && (rd_count != '1)) rd_count <= rd_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regbank_read_unit.sv
// Self-checking bench for regbank_read_unit: directed scenarios followed by random traffic
// compared against a transaction-level model of the read unit and its register bank.
module tb_regbank_read_unit;

    localparam int unsigned NREGS = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 16;

    logic                clk;
    logic                rst_n;
    logic [NREGS*DW-1:0] regs_flat;
    logic [NREGS-1:0]    wr_en;
    logic [DW-1:0]       wr_data;
    logic                wr_onehot_err;
    logic [CNT_W-1:0]    rd_count;

    logic [DW-1:0] bank [NREGS];

    regbank_read_unit_if #(.DW(DW)) bus ();

    regbank_read_unit #(
        .NREGS(NREGS),
        .DW(DW),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .regs_flat(regs_flat),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .bus(bus),
        .wr_onehot_err(wr_onehot_err),
        .rd_count(rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) regs_flat[i*DW +: DW] = bank[i];
    end

    int unsigned vectors;
    int unsigned miscompares;

    // Model: one response slot, its operands, completed-read count, sticky error.
    bit            m_full;
    logic [DW-1:0] m_a;
    logic [DW-1:0] m_b;
    int unsigned   m_cnt;
    bit            m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] operand(input logic [3:0] idx);
`ifdef REGBANK_READ_R0_ZERO_EN
        if (idx == 4'd0) return '0;
`endif
        if ($countones(wr_en) == 1 && wr_en[idx]) return wr_data;
        return bank[idx];
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    // Entered just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic cycle();
        bit rdy, acc, take;
        #1;
        rdy  = !m_full || bus.rsp_ready;
        check("req_ready", 64'(bus.req_ready), 64'(rdy));
        acc  = bus.req_valid && rdy;
        take = m_full && bus.rsp_ready;
        if ($countones(wr_en) > 1) m_err = 1'b1;
        if (take && m_cnt < 65535) m_cnt++;
        if (acc) begin
            m_a    = operand(bus.src_a);
            m_b    = operand(bus.src_b);
            m_full = 1'b1;
        end else if (take) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_full));
        check("data_a", 64'(bus.data_a), 64'(m_a));
        check("data_b", 64'(bus.data_b), 64'(m_b));
        check("rd_count", 64'(rd_count), 64'(m_cnt));
        check("onehot_err", 64'(wr_onehot_err), 64'(m_err));
        // The bank itself commits the write at this edge.
        for (int i = 0; i < NREGS; i++) if (wr_en[i]) bank[i] = wr_data;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, "_data_a"}, 64'(bus.data_a), 64'(0));
        check({tag, "_data_b"}, 64'(bus.data_b), 64'(0));
        check({tag, "_rd_count"}, 64'(rd_count), 64'(0));
        check({tag, "_err"}, 64'(wr_onehot_err), 64'(0));
    endtask

    logic [DW-1:0] held;
    logic [DW-1:0] r0_exp;

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < NREGS; i++) bank[i] = $urandom;
        wr_en         = '0;
        wr_data       = '0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        rst_n         = 1'b0;
        model_reset();

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state("reset");
        check("reset_req_ready", 64'(bus.req_ready), 64'(1));

        // Basic read
        bank[3]       = 32'h0628_0060;
        bank[9]       = 32'h0608_0020;
        bus.src_a     = 4'd3;
        bus.src_b     = 4'd9;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        cycle();
        check("basic_a", 64'(bus.data_a), 64'h0628_0060);
        check("basic_b", 64'(bus.data_b), 64'h0608_0020);
        bus.req_valid = 1'b0;
        cycle();
        check("basic_count", 64'(rd_count), 64'd1);

        // Forwarding of a same-cycle write
        wr_en         = 16'h0200;
        wr_data       = 32'hDEAD_BEEF;
        bus.src_a     = 4'd9;
        bus.src_b     = 4'd3;
        bus.req_valid = 1'b1;
        cycle();
        check("fwd_a", 64'(bus.data_a), 64'hDEAD_BEEF);
        check("fwd_b", 64'(bus.data_b), 64'h0628_0060);
        wr_en = '0;

        // Backpressure: held snapshot while R0 keeps changing, queued second request
        bank[0]   = 32'hA0A0_0001;
        bus.src_a = 4'd0;
        bus.src_b = 4'd0;
        cycle();
        held          = bank[0];
        bus.rsp_ready = 1'b0;
        bus.src_a     = 4'd3;
        bus.src_b     = 4'd9;
        for (int k = 0; k < 3; k++) begin
            bank[0] = $urandom;
            cycle();
            check("hold_a", 64'(bus.data_a), 64'(held));
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check("bp_next_a", 64'(bus.data_a), 64'h0628_0060);
        check("bp_next_b", 64'(bus.data_b), 64'hDEAD_BEEF);
        bus.req_valid = 1'b0;
        cycle();

        // R0 handling with a forwarded write to R0
        bank[0]       = 32'h1234_5678;
        wr_en         = 16'h0001;
        wr_data       = 32'hCAFE_F00D;
        bus.src_a     = 4'd0;
        bus.req_valid = 1'b1;
`ifdef REGBANK_READ_R0_ZERO_EN
        r0_exp = 32'h0;
`else
        r0_exp = 32'hCAFE_F00D;
`endif
        cycle();
        check("r0_a", 64'(bus.data_a), 64'(r0_exp));
        wr_en         = '0;
        bus.req_valid = 1'b0;
        cycle();

        // Multi-hot: not forwarded, sticky error
        wr_en         = 16'h0003;
        wr_data       = 32'h5555_AAAA;
        bank[1]       = 32'h0000_0011;
        bus.src_a     = 4'd1;
        bus.src_b     = 4'd0;
        bus.req_valid = 1'b1;
        cycle();
        check("multi_err", 64'(wr_onehot_err), 64'd1);
        check("multi_nofwd_a", 64'(bus.data_a), 64'h0000_0011);
        wr_en         = '0;
        bus.req_valid = 1'b0;
        repeat (2) cycle();
        check("multi_sticky", 64'(wr_onehot_err), 64'd1);

        // Asynchronous reset while FULL
        bus.src_a     = 4'd3;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        cycle();
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.src_a     = 4'($urandom_range(0, 15));
            bus.src_b     = ($urandom_range(0, 7) == 0) ? bus.src_a : 4'($urandom_range(0, 15));
            wr_data       = $urandom;
            sel           = $urandom_range(0, 19);
            if (sel < 9)       wr_en = '0;
            else if (sel < 19) wr_en = 16'(1) << $urandom_range(0, 15);
            else               wr_en = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bank[$urandom_range(0, 15)] = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
